// File: rtl/vliw_run_ctrl.sv
// Host-facing run/load controller for the slice VLIW sequencer: assembles 72-bit words, gates vliw_start on frame boundaries.
// Optional feature: define VLIW_RUN_CTRL_FRAME_COUNT_EN to build a 16-bit frame counter reported in status[15:8].
module vliw_run_ctrl #(
    parameter int FRAME_LEN = 10,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 72
) (
    input  logic              clock_200,
    input  logic              reset,
    input  logic              host_wr,
    input  logic              host_rd,
    input  logic [2:0]        host_addr,
    input  logic [15:0]       host_wdata,
    output logic [15:0]       host_rdata,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              vliw_start,
    output logic              frame_tick
);
    localparam int PH_W = 4;

    typedef enum logic [1:0] {STOPPED, LOAD, RUNNING, DRAINING} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       lane_reg [4];
    logic [63:0]       lanes_cat;
    logic [7:0]        lane_hi_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              run_reg, autoinc_reg, err_reg;
    logic [PH_W-1:0]   phase_reg;
    logic              draining;
    logic              ctrl_wr, run_eff, commit, errclr, phase_last;
    logic [7:0]        frame_lo;
    logic [15:0]       rd_mux;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_cat
        assign lanes_cat[gi*16 +: 16] = lane_reg[gi];
    end

    // A control write takes effect on the same edge it is sampled, so the FSM looks at the incoming RUN bit.
    assign ctrl_wr    = host_wr && (host_addr == 3'd6);
    assign run_eff    = ctrl_wr ? host_wdata[0] : run_reg;
    assign commit     = ctrl_wr && host_wdata[1];
    assign errclr     = ctrl_wr && host_wdata[3];
    assign phase_last = (phase_reg == PH_W'(FRAME_LEN - 1));

    always_ff @(negedge clock_200) begin
        if (reset) state_reg <= STOPPED;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOPPED:  if (commit) state_next = LOAD;
                      else if (run_eff) state_next = RUNNING;
            LOAD:     state_next = run_eff ? RUNNING : STOPPED;
            RUNNING:  if (!run_eff) state_next = phase_last ? STOPPED : DRAINING;
            DRAINING: if (run_eff) state_next = RUNNING;
                      else if (phase_last) state_next = STOPPED;
            default:  state_next = STOPPED;
        endcase
    end

    always_comb begin
        write_enable = (state_reg == LOAD);
        vliw_start   = (state_reg == RUNNING) || (state_reg == DRAINING);
        draining     = (state_reg == DRAINING);
        frame_tick   = vliw_start && phase_last;
    end

`ifdef VLIW_RUN_CTRL_FRAME_COUNT_EN
    logic [15:0] frame_cnt_reg;
    always_ff @(negedge clock_200) begin
        if (reset)           frame_cnt_reg <= '0;
        else if (frame_tick) frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
    assign frame_lo = frame_cnt_reg[7:0];
`else
    assign frame_lo = 8'h00;
`endif

    always_comb begin
        rd_mux = '0;
        case (host_addr)
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = lane_reg[host_addr[1:0]];
            3'd4:    rd_mux = {8'h00, lane_hi_reg};
            3'd5:    rd_mux = 16'(addr_reg);
            3'd6:    rd_mux = {13'b0, autoinc_reg, 1'b0, run_reg};
            default: rd_mux = {frame_lo, phase_reg, err_reg, write_enable, draining, vliw_start};
        endcase
    end

    always_ff @(negedge clock_200) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) lane_reg[i] <= '0;
            lane_hi_reg   <= '0;
            addr_reg      <= '0;
            run_reg       <= 1'b0;
            autoinc_reg   <= 1'b0;
            err_reg       <= 1'b0;
            phase_reg     <= '0;
            write_address <= '0;
            write_data    <= '0;
            host_rdata    <= '0;
        end else begin
            if (vliw_start) phase_reg <= phase_last ? '0 : phase_reg + 1'b1;
            // Set wins over clear so a rejected COMMIT is never lost.
            err_reg <= (err_reg && !errclr) || (commit && vliw_start);
            if (state_reg == STOPPED && commit) begin
                write_address <= addr_reg;
                write_data    <= DATA_W'({lane_hi_reg, lanes_cat});
            end
            for (int i = 0; i < 4; i++)
                if (host_wr && host_addr == 3'(i)) lane_reg[i] <= host_wdata;
            if (host_wr && host_addr == 3'd4) lane_hi_reg <= host_wdata[7:0];
            if (host_wr && host_addr == 3'd5) addr_reg <= host_wdata[ADDR_W-1:0];
            else if (state_reg == LOAD && autoinc_reg) addr_reg <= addr_reg + 1'b1;
            if (ctrl_wr) begin
                run_reg     <= host_wdata[0];
                autoinc_reg <= host_wdata[2];
            end
            if (host_rd) host_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_vliw_run_ctrl.sv
// Self-checking bench for vliw_run_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_vliw_run_ctrl;
    localparam int FL = 10;

    logic        clock_200 = 1'b0;
    logic        reset = 1'b1, host_wr = 1'b0, host_rd = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic        write_enable, vliw_start, frame_tick;
    logic [8:0]  write_address;
    logic [71:0] write_data;

    int checks = 0, errors = 0, cyc = 0;
    bit verbose = 1'b1;

    // Reference model state, advanced once per DUT (falling) edge.
    logic [15:0] m_lane [4];
    logic [7:0]  m_hi;
    logic [8:0]  m_addr, m_waddr;
    logic [71:0] m_wdata;
    logic [15:0] m_rdata;
    bit          m_run, m_auto, m_err, m_start, m_we;
    int          m_phase, m_fcnt;

    vliw_run_ctrl dut (
        .clock_200(clock_200), .reset(reset), .host_wr(host_wr), .host_rd(host_rd),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .vliw_start(vliw_start), .frame_tick(frame_tick)
    );

    always #5 clock_200 = ~clock_200;

    function automatic logic [15:0] m_reg(input logic [2:0] a);
        logic [7:0] fc;
`ifdef VLIW_RUN_CTRL_FRAME_COUNT_EN
        fc = 8'(m_fcnt % 256);
`else
        fc = 8'h00;
`endif
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_lane[a[1:0]];
            3'd4: return {8'h00, m_hi};
            3'd5: return {7'b0, m_addr};
            3'd6: return {13'b0, m_auto, 1'b0, m_run};
            default: return {fc, 4'(m_phase), m_err, m_we, (m_start && !m_run), m_start};
        endcase
    endfunction

    task automatic model_step(input bit rst, wr, rd, input logic [2:0] a, input logic [15:0] d);
        logic [15:0] rv;
        bit ctrl, run_eff, commit, tick;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_lane[i] = '0;
            m_hi = '0; m_addr = '0; m_waddr = '0; m_wdata = '0; m_rdata = '0;
            m_run = 0; m_auto = 0; m_err = 0; m_start = 0; m_we = 0; m_phase = 0; m_fcnt = 0;
            return;
        end
        rv      = m_reg(a);
        ctrl    = wr && a == 3'd6;
        run_eff = ctrl ? d[0] : m_run;
        commit  = ctrl && d[1];
        tick    = m_start && m_phase == FL - 1;
        if (rd) m_rdata = rv;
        if (ctrl && d[3]) m_err = 0;
        if (m_start) begin
            if (commit) m_err = 1;
            if (tick) m_fcnt = (m_fcnt + 1) % 65536;
            m_phase = (m_phase + 1) % FL;
            if (!run_eff && tick) m_start = 0;
        end else if (m_we) begin
            m_we = 0;
            if (m_auto) m_addr = m_addr + 9'd1;
            m_start = run_eff;
        end else if (commit) begin
            m_we = 1; m_waddr = m_addr;
            m_wdata = {m_hi, m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        end else if (run_eff) begin
            m_start = 1;
        end
        if (wr) begin
            if (a < 3'd4) m_lane[a[1:0]] = d;
            else if (a == 3'd4) m_hi = d[7:0];
            else if (a == 3'd5) m_addr = d[8:0];
            else if (a == 3'd6) begin m_run = d[0]; m_auto = d[2]; end
        end
    endtask

    // One DUT cycle: drive at rising edge, DUT samples on the falling edge, observe at the next rising edge.
    task automatic cycle(input bit rst, wr, rd, input logic [2:0] a, input logic [15:0] d);
        reset = rst; host_wr = wr; host_rd = rd; host_addr = a; host_wdata = d;
        @(posedge clock_200);
        model_step(rst, wr, rd, a, d);
        cyc++;
        if (verbose && (rst || wr || rd))
            $display("cyc %0d rst=%0d wr=%0d rd=%0d addr=%0d data=%h -> we=%0d start=%0d tick=%0d rdata=%h",
                     cyc, rst, wr, rd, a, d, write_enable, vliw_start, frame_tick, host_rdata);
        reset = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 3'd0, 16'h0);
    endtask

    task automatic wait_stop(input string name);
        int n;
        n = 0;
        while (vliw_start === 1'b1 && n < 30) begin idle(1); n++; end
        checks++;
        if (vliw_start !== 1'b0) begin
            errors++; $display("FAIL %s_stop: vliw_start=%b required 0 within 30 cycles", name, vliw_start);
        end
    endtask

    task automatic test_reset();
        logic [99:0] outs;
        cycle(1, 0, 0, 3'd0, 16'h0);
        cycle(1, 0, 0, 3'd0, 16'h0);
        outs = {write_enable, write_address, write_data, vliw_start, frame_tick, host_rdata};
        checks++;
        if (outs !== 100'h0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h required 0000", host_rdata); end
    endtask

    task automatic test_load();
        cycle(0, 1, 0, 3'd0, 16'h1111);
        cycle(0, 1, 0, 3'd1, 16'h2222);
        cycle(0, 1, 0, 3'd2, 16'h3333);
        cycle(0, 1, 0, 3'd3, 16'h4444);
        cycle(0, 1, 0, 3'd4, 16'hAB55);
        cycle(0, 1, 0, 3'd5, 16'h01FF);
        cycle(0, 1, 0, 3'd6, 16'h0006);
        checks++;
        if (write_enable !== 1'b1) begin errors++; $display("FAIL load_we: got %b required 1", write_enable); end
        checks++;
        if (write_address !== 9'h1FF) begin errors++; $display("FAIL load_addr: got %h required 1ff", write_address); end
        checks++;
        if (write_data !== 72'h55_4444_3333_2222_1111) begin
            errors++; $display("FAIL load_data: got %h required 554444333322221111", write_data);
        end
        idle(1);
        checks++;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL load_we_width: got %b required 0", write_enable); end
        cycle(0, 0, 1, 3'd5, 16'h0);
        checks++;
        if (host_rdata !== 16'h0000) begin errors++; $display("FAIL load_autoinc_wrap: got %h required 0000", host_rdata); end
        cycle(0, 0, 1, 3'd4, 16'h0);
        checks++;
        if (host_rdata !== 16'h0055) begin errors++; $display("FAIL load_hi_lane: got %h required 0055", host_rdata); end
        cycle(0, 1, 1, 3'd6, 16'h0000);
        checks++;
        if (host_rdata !== 16'h0004) begin errors++; $display("FAIL load_ctrl_read: got %h required 0004", host_rdata); end
    endtask

    task automatic test_drain();
        int n, ticks;
        cycle(0, 1, 0, 3'd6, 16'h0001);
        checks++;
        if (vliw_start !== 1'b1) begin errors++; $display("FAIL drain_start: got %b required 1", vliw_start); end
        idle(3);
        cycle(0, 1, 0, 3'd6, 16'h0000);
        n = 1; ticks = 0;
        while (vliw_start === 1'b1 && n < 30) begin
            n++;
            if (frame_tick === 1'b1) ticks++;
            idle(1);
        end
        checks++;
        if (n !== 7) begin errors++; $display("FAIL drain_cycles: got %0d required 7", n); end
        checks++;
        if (ticks !== 1) begin errors++; $display("FAIL drain_ticks: got %0d required 1", ticks); end
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata[7:0] !== 8'h00) begin errors++; $display("FAIL drain_status: got %h required 00", host_rdata[7:0]); end
    endtask

    task automatic test_commit_err();
        cycle(0, 1, 0, 3'd6, 16'h0001);
        cycle(0, 1, 0, 3'd6, 16'h0003);
        checks++;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL err_no_write: got %b required 0", write_enable); end
        idle(1);
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata[7:0] !== 8'h29) begin errors++; $display("FAIL err_set: got %h required 29", host_rdata[7:0]); end
        cycle(0, 1, 0, 3'd6, 16'h0009);
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata[7:0] !== 8'h41) begin errors++; $display("FAIL err_clear: got %h required 41", host_rdata[7:0]); end
        cycle(0, 1, 0, 3'd6, 16'h000B);
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata[7:0] !== 8'h69) begin errors++; $display("FAIL err_set_wins: got %h required 69", host_rdata[7:0]); end
        cycle(0, 1, 0, 3'd6, 16'h0008);
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata[7:0] !== 8'h83) begin errors++; $display("FAIL err_draining: got %h required 83", host_rdata[7:0]); end
        wait_stop("err");
    endtask

    task automatic test_resume();
        int steps [40];
        int t0, gap, ticks, bad;
        for (int i = 0; i < 40; i++) steps[i] = -1;
        steps[2] = 0;
        steps[6] = 1;
        cycle(0, 1, 0, 3'd6, 16'h0001);
        t0 = cyc; gap = 0; ticks = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (vliw_start !== 1'b1) gap++;
            if (frame_tick === 1'b1) begin
                ticks++;
                if ((cyc - t0) % FL != FL - 1) bad++;
            end
            if (steps[i] < 0) idle(1);
            else cycle(0, 1, 0, 3'd6, 16'(steps[i]));
        end
        checks++;
        if (gap !== 0) begin errors++; $display("FAIL resume_gap: got %0d idle cycles required 0", gap); end
        checks++;
        if (ticks !== 4 || bad !== 0) begin
            errors++; $display("FAIL resume_ticks: got %0d ticks (%0d misplaced) required 4 (0)", ticks, bad);
        end
        cycle(0, 1, 0, 3'd6, 16'h0000);
        wait_stop("resume");
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 3'd6, 16'h0001);
        idle(5);
        cycle(1, 0, 0, 3'd0, 16'h0);
        checks++;
        if (vliw_start !== 1'b0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL midreset_drop: start=%b tick=%b required 0 0", vliw_start, frame_tick);
        end
        cycle(0, 1, 0, 3'd6, 16'h0001);
        cycle(0, 0, 1, 3'd7, 16'h0);
        checks++;
        if (host_rdata !== 16'h0001) begin errors++; $display("FAIL midreset_restart: got %h required 0001", host_rdata); end
        cycle(0, 1, 0, 3'd6, 16'h0000);
        wait_stop("midreset");
    endtask

    task automatic test_random();
        logic [99:0] got, exp;
        bit rst, wr, rd;
        logic [2:0] a;
        logic [15:0] d;
        int shown;
        verbose = 1'b0;
        shown = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            a   = 3'($urandom_range(0, 7));
            d   = 16'($urandom);
            cycle(rst, wr, rd, a, d);
            got = {write_enable, write_address, write_data, vliw_start, frame_tick, host_rdata};
            exp = {m_we, m_waddr, m_wdata, m_start, (m_start && m_phase == FL - 1), m_rdata};
            checks++;
            if (got !== exp) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cyc%0d: got %h required %h", cyc, got, exp);
                end
            end
        end
    endtask

    initial begin
        @(posedge clock_200);
        test_reset();
        test_load();
        test_drain();
        test_commit_err();
        test_resume();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
